// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative MIPS multiply/divide unit owning the HI/LO registers.
//
// One radix-2 step per clock: shift-add for mult/multu, restoring
// shift-subtract for div/divu. Signed operations run on operand magnitudes
// and the result signs are applied on the final edge, so HI/LO only ever
// change on a completed operation, an mthi/mtlo write, or reset.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset; aborts any running operation
//   start, op    launch request and opcode (00 mult, 01 multu, 10 div, 11 divu)
//   a, b         [rs]/[rt] operands, sampled with an accepted start
//   wr_hi, wr_lo mthi/mtlo strobes, honoured only while idle
//   din          mthi/mtlo data
//   busy         operation in progress
//   done         one-cycle pulse on the edge HI/LO take a result
//   hi, lo       HI/LO registers (registered outputs only)
//
// Handshake: start is accepted on an edge where busy is low; busy rises on
// that same edge and stays high for ITERS cycles. The edge that writes the
// result drops busy and pulses done; a start presented on that edge is
// ignored, so the earliest new launch is the following edge. While busy,
// start and wr_hi/wr_lo are ignored. start beats wr_hi/wr_lo when idle.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int ITERS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

    typedef enum logic [0:0] {IDLE, RUN} state_t;

    // state is the observable FSM state for checkers.
    state_t state, state_nx;

    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               sign_q;    // negate product / quotient
    logic               sign_r;    // negate remainder (dividend sign)
    logic               div0;      // divide by zero: quotient forced to all ones
    logic [WIDTH-1:0]   mag_b;     // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] p;         // {upper accumulator/remainder, multiplier/quotient}

    logic last;
    assign last = (state == RUN) && (cnt == CW'(ITERS - 1));
    assign busy = (state == RUN);

    // Operand magnitudes. Sign extension to WIDTH+1 bits makes the negation
    // of the most negative value exact; its top bit is always zero.
    logic               signed_op, a_neg, b_neg;
    logic [WIDTH:0]     a_sx, b_sx, a_mag, b_mag;
    assign signed_op = ~op[0];
    assign a_neg     = signed_op & a[WIDTH-1];
    assign b_neg     = signed_op & b[WIDTH-1];
    assign a_sx      = {a[WIDTH-1], a};
    assign b_sx      = {b[WIDTH-1], b};
    assign a_mag     = a_neg ? -a_sx : {1'b0, a};
    assign b_mag     = b_neg ? -b_sx : {1'b0, b};

    // Multiply step: conditionally add multiplicand into the upper half,
    // then shift the whole product right; the carry lands in bit 2W-1.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nx;
    assign mul_sum = {1'b0, p[2*WIDTH-1:WIDTH]}
                   + (p[0] ? {1'b0, mag_b} : {(WIDTH+1){1'b0}});
    assign mul_nx  = {mul_sum, p[WIDTH-1:1]};

    // Divide step: shift left, trial-subtract the divisor from the upper
    // WIDTH+1 bits, keep the difference and set the quotient bit on no borrow.
    logic [2*WIDTH:0]   div_sh;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] div_nx;
    assign div_sh   = {p, 1'b0};
    assign div_diff = {1'b0, div_sh[2*WIDTH:WIDTH]} - {2'b00, mag_b};
    assign div_nx   = div_diff[WIDTH+1] ? div_sh[2*WIDTH-1:0]
                                        : {div_diff[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};

    logic [2*WIDTH-1:0] step_nx;
    assign step_nx = is_div ? div_nx : mul_nx;

    // Sign-corrected result from the final step.
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;
    always_comb begin
        prod   = sign_q ? -step_nx : step_nx;
        quo    = sign_q ? -step_nx[WIDTH-1:0] : step_nx[WIDTH-1:0];
        rem    = sign_r ? -step_nx[2*WIDTH-1:WIDTH] : step_nx[2*WIDTH-1:WIDTH];
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div) begin
            res_hi = rem;
            res_lo = div0 ? {WIDTH{1'b1}} : quo;
        end
    end

    // A remainder never exceeds the divisor, so bit WIDTH of an accepted
    // difference is always zero; the magnitude top bits are zero likewise.
    logic unused_bits;
    assign unused_bits = ^{div_diff[WIDTH], a_mag[WIDTH], b_mag[WIDTH]};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            div0   <= 1'b0;
            mag_b  <= '0;
            p      <= '0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    is_div <= op[1];
                    sign_q <= a_neg ^ b_neg;
                    sign_r <= a_neg;
                    div0   <= op[1] && (b == '0);
                    cnt    <= '0;
                    // Divide: dividend in the low half, divisor held aside.
                    // Multiply: multiplier (b) in the low half, multiplicand (a) aside.
                    if (op[1]) begin
                        p     <= {{WIDTH{1'b0}}, a_mag[WIDTH-1:0]};
                        mag_b <= b_mag[WIDTH-1:0];
                    end else begin
                        p     <= {{WIDTH{1'b0}}, b_mag[WIDTH-1:0]};
                        mag_b <= a_mag[WIDTH-1:0];
                    end
                end else begin
                    if (wr_hi) hi <= din;
                    if (wr_lo) lo <= din;
                end
            end else begin
                p   <= step_nx;
                cnt <= cnt + CW'(1);
                if (last) begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    done <= 1'b1;
                    cnt  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- directed test of muldiv_unit: reset values, mult/multu,
// div/divu including divide-by-zero and signed overflow, start while busy,
// start on the result edge, reset mid-operation and mthi/mtlo writes.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] din;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int passed = 0;
  int total  = 0;

  // expected HI/LO contents
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  muldiv_unit #(.WIDTH(32), .ITERS(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .wr_hi (wr_hi),
    .wr_lo (wr_lo),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // mode 0: plain; 1: wr_lo held during RUN; 2: wr_hi with start;
  // 3: raise start for the next op just before the result edge and return
  //    with it still high (next call's first edge is N+33).
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el,
                        input int mode, input string tag);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    if (mode == 2) begin
      wr_hi = 1'b1;
      din   = 32'h5555_AAAA;
    end
    tick();
    start = 1'b0;
    wr_hi = 1'b0;
    a     = $urandom;
    b     = $urandom;
    op    = 2'($urandom_range(0, 3));
    if (mode == 1) begin
      wr_lo = 1'b1;
      din   = 32'hDEAD_BEEF;
    end
    check({tag, "/busy_start"}, 32'(busy), 32'd1);
    check({tag, "/done_start"}, 32'(done), 32'd0);
    for (int k = 1; k < 32; k++) begin
      if (k == 31 && mode == 3) begin
        start = 1'b1;
        op    = OP_DIVU;
        a     = 32'd7;
        b     = 32'd2;
      end
      tick();
      check({tag, "/busy_run"}, 32'(busy), 32'd1);
      check({tag, "/done_run"}, 32'(done), 32'd0);
      check({tag, "/hi_hold"}, hi, m_hi);
      check({tag, "/lo_hold"}, lo, m_lo);
    end
    tick();
    wr_lo = 1'b0;
    check({tag, "/done_end"}, 32'(done), 32'd1);
    check({tag, "/busy_end"}, 32'(busy), 32'd0);
    check({tag, "/hi"}, hi, eh);
    check({tag, "/lo"}, lo, el);
    m_hi = eh;
    m_lo = el;
    if (mode != 3) begin
      tick();
      check({tag, "/done_pulse"}, 32'(done), 32'd0);
      check({tag, "/hi_after"}, hi, eh);
      check({tag, "/lo_after"}, lo, el);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    din   = '0;
    m_hi  = '0;
    m_lo  = '0;
    tick();
    tick();
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/done", 32'(done), 32'd0);
    check("reset/hi", hi, 32'd0);
    check("reset/lo", lo, 32'd0);
    rst = 1'b0;
    tick();

    // multiplies
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, "multu_max");
    run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, "mult_neg");
    run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0, "mult_min");

    // divides; divu 7/2 leaves start raised on its result edge
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, "div_negdvd");
    run_op(OP_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         3, "divu_7_2");
    run_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 0, "div_negdvs");

    // boundary divides
    run_op(OP_DIVU,  32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 0, "divu_by0");
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 0, "div_by0_neg");
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, "div_ovf");

    // start while busy is ignored
    start = 1'b1; op = OP_MULTU; a = 32'd5; b = 32'd6;
    tick();
    start = 1'b0;
    for (int k = 1; k < 32; k++) begin
      if (k == 5) begin
        start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd10;
      end
      tick();
      start = 1'b0;
      check("busy_start/busy", 32'(busy), 32'd1);
    end
    tick();
    check("busy_start/done", 32'(done), 32'd1);
    check("busy_start/hi", hi, 32'd0);
    check("busy_start/lo", lo, 32'd30);
    tick();

    // reset mid-operation
    start = 1'b1; op = OP_MULTU; a = 32'd5; b = 32'd6;
    tick();
    start = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst/busy", 32'(busy), 32'd0);
    check("midrst/done", 32'(done), 32'd0);
    check("midrst/hi", hi, 32'd0);
    check("midrst/lo", lo, 32'd0);
    m_hi = '0;
    m_lo = '0;
    for (int k = 0; k < 26; k++) begin
      tick();
      check("midrst/no_done", 32'(done), 32'd0);
      check("midrst/idle", 32'(busy), 32'd0);
    end
    run_op(OP_MULTU, 32'd9, 32'd9, 32'd0, 32'd81, 0, "after_rst");

    // mthi / mtlo in IDLE
    wr_hi = 1'b1; din = 32'hCAFE_0001;
    tick();
    wr_hi = 1'b0;
    check("mthi/hi", hi, 32'hCAFE_0001);
    check("mthi/lo", lo, 32'd81);
    check("mthi/done", 32'(done), 32'd0);
    wr_hi = 1'b1; wr_lo = 1'b1; din = 32'h0BAD_F00D;
    tick();
    wr_hi = 1'b0; wr_lo = 1'b0;
    check("mtboth/hi", hi, 32'h0BAD_F00D);
    check("mtboth/lo", lo, 32'h0BAD_F00D);
    check("mtboth/done", 32'(done), 32'd0);
    m_hi = 32'h0BAD_F00D;
    m_lo = 32'h0BAD_F00D;

    // mtlo during RUN ignored; start with mthi drops the write
    run_op(OP_DIVU,  32'd7, 32'd2, 32'd1, 32'd3,  1, "mtlo_run");
    run_op(OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, 2, "start_mthi");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
